// File: rtl/sfifo_reader_if.sv
// Stream bundle between sfifo_reader, its sfifo read port and the downstream consumer.
// A word moves on m_data in every cycle where m_valid && m_ready; once m_valid rises it and m_data hold until accepted.
interface sfifo_reader_if #(
    parameter int WIDTH = 8
);
    logic             rempty;
    logic [WIDTH-1:0] rdata;
    logic             rinc;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        input  rempty,
        input  rdata,
        input  m_ready,
        output rinc,
        output m_valid,
        output m_data
    );

    modport slave (
        output rempty,
        output rdata,
        output m_ready,
        input  rinc,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/sfifo_reader.sv
// Read-side master for sfifo: paced reads, 1-cycle read-latency capture and a
// 2-entry skid buffer feeding a valid/ready stream, plus a drained-word counter.
module sfifo_reader #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    sfifo_reader_if.master   bus,
    output logic [CNT_W-1:0] drained,
    output logic             busy
);
    logic             r_guard;
    logic             r_inflight;
    logic [1:0]       r_occ;
    logic             r_head;
    logic             r_tail;
    logic [WIDTH-1:0] r_mem [2];
    logic [CNT_W-1:0] r_drained;

    logic w_rinc;
    logic w_push;
    logic w_pop;

    // r_inflight doubles as "rinc last cycle", so requiring it low also makes occ+inflight == occ.
    assign w_rinc = !r_guard && !bus.rempty && !r_inflight && !r_occ[1];
    assign w_push = r_inflight;
    assign w_pop  = (r_occ != 2'd0) && bus.m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_guard    <= 1'b1;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_drained  <= '0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_guard    <= 1'b0;
            r_inflight <= w_rinc;
            r_occ      <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) begin
                r_mem[r_tail] <= bus.rdata;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head    <= ~r_head;
                r_drained <= r_drained + 1'b1;
            end
        end
    end

    assign bus.rinc    = w_rinc;
    assign bus.m_valid = (r_occ != 2'd0);
    assign bus.m_data  = r_mem[r_head];
    assign drained     = r_drained;
    assign busy        = r_inflight | (r_occ != 2'd0);
endmodule

// File: tb/tb_sfifo_reader.sv
// Bench for sfifo_reader: behavioural sfifo with a stale empty flag, write-order
// scoreboard, and a negedge monitor checking stream, pacing and counters.
module tb_sfifo_reader;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sfifo_reader_if #(.WIDTH(WIDTH)) bus ();
    logic [CNT_W-1:0] drained;
    logic             busy;

    sfifo_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .drained (drained),
        .busy    (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             mdl_rempty;
    logic [WIDTH-1:0] mdl_rdata;
    logic             ready_q = 1'b1;
    logic             ready_rand = 1'b0;

    assign bus.rempty  = mdl_rempty;
    assign bus.rdata   = mdl_rdata;
    assign bus.m_ready = ready_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // sfifo model: empty flag reflects occupancy before this edge's read, i.e. one cycle stale
    always @(posedge clk or negedge rst_n) begin : mdl_p
        int sz;
        if (!rst_n) begin
            fifo_q.delete();
            mdl_rempty <= 1'b0;
            mdl_rdata  <= '0;
        end else begin
            sz = fifo_q.size();
            mdl_rempty <= (sz == 0);
            if (bus.rinc) begin
                check("fifo_underflow", 32'(sz != 0), 32'd1);
                if (sz != 0) mdl_rdata <= fifo_q.pop_front();
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (ready_rand) ready_q = 1'($urandom_range(0, 1));
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int               n_fetch = 0;
    int               n_acc = 0;
    int               first_rinc_cyc = -1;
    int               first_valid_cyc = -1;
    logic             prev_rinc = 1'b0;
    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic [CNT_W-1:0] exp_drained = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_rinc", 32'(bus.rinc), 32'd0);
            check("rst_valid", 32'(bus.m_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_drained", 32'(drained), 32'd0);
            check("rst_data", 32'(bus.m_data), 32'd0);
            n_fetch = 0; n_acc = 0; prev_rinc = 1'b0; prev_hold = 1'b0;
            exp_drained = '0; first_rinc_cyc = -1; first_valid_cyc = -1;
            exp_q.delete();
        end else begin
            check("drained", 32'(drained), 32'(exp_drained));
            check("busy", 32'(busy), 32'(n_fetch != n_acc));
            check("occupancy_bound", 32'((n_fetch - n_acc) <= 2), 32'd1);
            if (prev_hold) begin
                check("hold_valid", 32'(bus.m_valid), 32'd1);
                check("hold_data", 32'(bus.m_data), 32'(prev_data));
            end
            if (bus.rinc) begin
                check("rinc_spacing", 32'(prev_rinc), 32'd0);
                n_fetch++;
                if (first_rinc_cyc < 0) first_rinc_cyc = cyc;
            end
            if (bus.m_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                check("valid_has_word", 32'(exp_q.size() != 0), 32'd1);
                if (bus.m_ready && exp_q.size() != 0) begin
                    check("m_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
                    exp_drained = exp_drained + 1'b1;
                    n_acc++;
                end
            end
            prev_rinc = bus.rinc;
            prev_hold = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
        end
    end

    task automatic write_word(input logic [WIDTH-1:0] d);
        @(posedge clk);
        #1;
        fifo_q.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int max_cyc);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !busy) done = 1'b1;
        end
        check("drain_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic found;
        // startup guard: rempty is driven low (invalid) right after release
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("guard_rinc", 32'(bus.rinc), 32'd0);
        repeat (5) @(posedge clk);
        #2 check("idle_valid", 32'(bus.m_valid), 32'd0);

        // three words, free-flowing
        write_word(8'h11); write_word(8'h22); write_word(8'h33);
        wait_drain(100);
        check("first_latency", 32'(first_valid_cyc - first_rinc_cyc), 32'd2);
        check("drained_3", 32'(drained), 32'd3);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rinc", 32'(bus.rinc), 32'd0);

        // backpressure: only two words may be fetched
        do_reset();
        ready_q = 1'b0;
        write_word(8'h11); write_word(8'h22); write_word(8'h33); write_word(8'h44);
        repeat (20) @(posedge clk);
        #2;
        check("bp_fetched", 32'(n_fetch), 32'd2);
        check("bp_valid", 32'(bus.m_valid), 32'd1);
        check("bp_data", 32'(bus.m_data), 32'h11);
        ready_q = 1'b1;
        wait_drain(100);
        check("bp_drained", 32'(drained), 32'd4);

        // single word: stale rempty must not trigger a second read
        do_reset();
        write_word(8'h5a);
        wait_drain(50);
        repeat (6) @(posedge clk);
        #2;
        check("last_fetch", 32'(n_fetch), 32'd1);
        check("last_acc", 32'(n_acc), 32'd1);

        // counter wrap at 2^CNT_W
        do_reset();
        ready_rand = 1'b1;
        for (int i = 0; i < 17; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            write_word(WIDTH'($urandom));
        end
        wait_drain(400);
        check("drained_wrap", 32'(drained), 32'd1);

        // long random run
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            write_word(WIDTH'($urandom));
        end
        wait_drain(2000);

        // reset while one word is buffered and one is in flight
        ready_rand = 1'b0;
        do_reset();
        ready_q = 1'b0;
        write_word(8'hA1); write_word(8'hB2);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk);
            #1;
            if (n_fetch == 2) found = 1'b1;
        end
        check("mid_reached", 32'(found), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_valid", 32'(bus.m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(bus.m_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_rinc", 32'(bus.rinc), 32'd0);
        ready_q = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        check("post_rst_valid", 32'(bus.m_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_drained", 32'(drained), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
